// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline control slice: register-select type and
// the hazard controller state encoding.
package cpu_types_pkg;

  localparam int unsigned REGBITS_W = 5;

  typedef logic [REGBITS_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    BUBBLE,
    REDIRECT,
    HALTED
  } hazard_state_t;

endpackage

// File: rtl/hazard_stat_ctr.sv
// Saturating event counter used for hazard statistics; clears on RST and
// holds at all-ones once reached.
module hazard_stat_ctr #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline (load-use, D-miss freeze,
// EX redirect squash, HALT). Define HAZARD_STATS_EN to add statistic counters.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int unsigned LOADUSE_BUBBLES = 1,
  parameter int unsigned REG_W           = 5,
  parameter int unsigned STAT_W          = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_dREN,
  input  logic [REG_W-1:0] idex_wsel,
  input  logic             ex_redirect,
  input  logic             exmem_dREN,
  input  logic             exmem_dWEN,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             halted
`ifdef HAZARD_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_stall_cyc,
  output logic [STAT_W-1:0] stat_flush_cnt
`endif
);

  if (LOADUSE_BUBBLES < 1 || LOADUSE_BUBBLES > 3 || STAT_W < 1) begin : g_bad_cfg
    $error("pipeline_hazard_ctrl: unsupported parameter set");
  end

  hazard_state_t state_q, state_d;
  logic [1:0]    bub_q, bub_d;

  logic mem_stall, advance, loaduse;

  assign mem_stall = (exmem_dREN | exmem_dWEN) & ~dhit;
  assign advance   = ihit & ~mem_stall;
  assign loaduse   = idex_dREN & (idex_wsel != '0) &
                     ((idex_wsel == ifid_rs) | (ifid_uses_rt & (idex_wsel == ifid_rt)));

  always_comb begin
    state_d    = state_q;
    bub_d      = bub_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    halted     = 1'b0;
    if (RST) begin
      state_d = RUN;
      bub_d   = '0;
    end else if (state_q == HALTED || memwb_halt) begin
      state_d = HALTED;
      halted  = 1'b1;
    end else if (mem_stall) begin
      // Full freeze: state and bubble count held so nothing pending is lost.
    end else if (!advance) begin
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      idex_flush = 1'b1;
      if (ex_redirect) begin
        state_d = REDIRECT;
        bub_d   = '0;
      end
    end else if (ex_redirect || state_q == REDIRECT) begin
      pc_en      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      state_d    = RUN;
      bub_d      = '0;
    end else if (state_q == BUBBLE || loaduse) begin
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      idex_flush = 1'b1;
      if (state_q == BUBBLE) begin
        bub_d = 2'(bub_q - 2'd1);
        if (bub_q == 2'd1) state_d = RUN;
      end else if (LOADUSE_BUBBLES > 1) begin
        state_d = BUBBLE;
        bub_d   = 2'(LOADUSE_BUBBLES - 1);
      end
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    bub_q   <= bub_d;
  end

`ifdef HAZARD_STATS_EN
  logic stall_inc, redirect_fire;

  assign stall_inc     = ~pc_en & ~halted;
  // Only a redirect fire raises pc_en together with ifid_flush.
  assign redirect_fire = pc_en & ifid_flush;

  hazard_stat_ctr #(.W(STAT_W)) u_stall_ctr (
    .CLK (CLK),
    .RST (RST),
    .inc (stall_inc),
    .cnt (stat_stall_cyc)
  );

  hazard_stat_ctr #(.W(STAT_W)) u_flush_ctr (
    .CLK (CLK),
    .RST (RST),
    .inc (redirect_fire),
    .cnt (stat_flush_cnt)
  );
`endif

endmodule
